// File: rtl/mips_pkg.sv
// Shared PC sequencer types and constants: FSM state encoding, PC increment and vectors.
package mips_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2,
        RET  = 2'd3
    } pcseq_state_t;

    localparam logic [31:0] PC_INCR      = 32'd4;
    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VECTOR   = 32'h8000_0180;

endpackage

// File: rtl/pc_next_mux.sv
// Priority next-PC selection while running: exc_req > eret > stall > jump > branch > pc+4.
// With PC_ALIGN_CHECK_EN defined, a misaligned selected target becomes an exception.
module pc_next_mux
    import mips_pkg::*;
(
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        exc_req,
    input  logic        eret,
    input  logic        in_exc,
    input  logic [31:0] epc,
    input  logic [31:0] pc_cur,
    output logic        pc_ld,
    output logic [31:0] pc_next,
    output logic        flush,
    output logic        take_exc,
    output logic        take_eret,
    output logic        addr_err
);

    logic        redirect;
    logic [31:0] target;

    always_comb begin
        pc_ld     = 1'b1;
        pc_next   = pc_cur + PC_INCR;
        flush     = 1'b0;
        take_exc  = 1'b0;
        take_eret = 1'b0;
        addr_err  = 1'b0;
        redirect  = 1'b0;
        target    = pc_cur;

        if (exc_req) begin
            take_exc = 1'b1;
        end else if (eret && in_exc) begin
            redirect  = 1'b1;
            target    = epc;
            take_eret = 1'b1;
        end else if (stall) begin
            pc_ld = 1'b0;
        end else if (jump) begin
            redirect = 1'b1;
            target   = jump_target;
        end else if (branch_taken) begin
            redirect = 1'b1;
            target   = branch_target;
        end

        if (redirect) begin
            pc_next = target;
        end

`ifdef PC_ALIGN_CHECK_EN
        // A misaligned redirect is turned into a trap instead of being fetched.
        if (redirect && (target[1:0] != 2'b00)) begin
            addr_err  = 1'b1;
            take_exc  = 1'b1;
            take_eret = 1'b0;
        end
`endif

        if (take_exc) begin
            pc_ld   = 1'b1;
            pc_next = EXC_VECTOR;
            flush   = 1'b1;
        end else if (take_eret) begin
            flush = 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer FSM (BOOT/RUN/TRAP/RET) with registered epc/in_exc; outputs combinational.
// Optional misaligned-target trap under macro PC_ALIGN_CHECK_EN.
module pc_sequencer
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] pc_cur,
    output logic        pc_ld,
    output logic [31:0] pc_next,
    output logic        fetch_valid,
    output logic        flush,
    output logic [31:0] epc,
    output logic        in_exc,
    output logic        addr_err
);

    pcseq_state_t state, state_d;
    logic [31:0]  epc_d;
    logic         in_exc_d;

    logic         mux_ld, mux_flush, mux_exc, mux_eret, mux_aerr;
    logic [31:0]  mux_next;

    pc_next_mux u_mux (
        .stall         (stall),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .exc_req       (exc_req),
        .eret          (eret),
        .in_exc        (in_exc),
        .epc           (epc),
        .pc_cur        (pc_cur),
        .pc_ld         (mux_ld),
        .pc_next       (mux_next),
        .flush         (mux_flush),
        .take_exc      (mux_exc),
        .take_eret     (mux_eret),
        .addr_err      (mux_aerr)
    );

    always_comb begin
        state_d     = state;
        epc_d       = epc;
        in_exc_d    = in_exc;
        pc_ld       = 1'b0;
        pc_next     = pc_cur;
        flush       = 1'b0;
        fetch_valid = 1'b0;
        addr_err    = 1'b0;

        case (state)
            BOOT: begin
                pc_ld   = 1'b1;
                pc_next = RESET_VECTOR;
                flush   = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                fetch_valid = 1'b1;
                pc_ld       = mux_ld;
                pc_next     = mux_next;
                flush       = mux_flush;
                addr_err    = mux_aerr;
                if (mux_exc) begin
                    state_d = TRAP;
                    // A nested exception keeps the original return address.
                    if (!in_exc) begin
                        epc_d    = pc_cur;
                        in_exc_d = 1'b1;
                    end
                end else if (mux_eret) begin
                    state_d  = RET;
                    in_exc_d = 1'b0;
                end
            end
            TRAP, RET: begin
                state_d = RUN;
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        if (reset) begin
            pc_ld       = 1'b1;
            pc_next     = RESET_VECTOR;
            flush       = 1'b1;
            fetch_valid = 1'b0;
            addr_err    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= BOOT;
            epc    <= 32'h0;
            in_exc <= 1'b0;
        end else begin
            state  <= state_d;
            epc    <= epc_d;
            in_exc <= in_exc_d;
        end
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 RESET_VECTOR, 32'hBFC0_0000, first fetch address after reset.
REQ-002 EXC_VECTOR, 32'h8000_0180, exception handler address.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  one clock; reset is synchronous and active-high.
REQ-005 stall  input  1  pipeline stall; hold the PC.
REQ-006 jump / jump_target  input  1 / 32  unconditional redirect and its target.
REQ-007 branch_taken / branch_target  input  1 / 32  resolved taken branch and its target.
REQ-008 exc_req  input  1  exception request.
REQ-009 eret  input  1  return from exception.
REQ-010 pc_cur  input  32  current PC register value.
REQ-011 pc_ld  output  1  load strobe to the PC register.
REQ-012 pc_next  output  32  value loaded when pc_ld=1.
REQ-013 fetch_valid  output  1  fetch at pc_cur is architecturally valid.
REQ-014 flush  output  1  squash in-flight instructions.
REQ-015 epc  output  32  saved exception PC; in_exc  output  1  handler mode.
REQ-016 addr_err  output  1  misaligned-target pulse (see Configuration).

Function
REQ-017 FSM states: BOOT, RUN, TRAP, RET; state, epc and in_exc are registered.
REQ-018 pc_ld, pc_next, flush and fetch_valid are combinational from state and inputs.
REQ-019 BOOT:
  - pc_ld=1, pc_next=RESET_VECTOR, flush=1, fetch_valid=0.
  - Next state RUN unconditionally.
REQ-020 RUN: fetch_valid=1; input priority exc_req > eret > stall > jump > branch_taken > sequential.
REQ-021 RUN exc_req (stall ignored):
  - pc_ld=1, pc_next=EXC_VECTOR, flush=1, next state TRAP.
  - If in_exc=0: epc<=pc_cur and in_exc<=1.
  - If in_exc=1: epc unchanged (nested exception).
REQ-022 RUN eret with in_exc=1:
  - pc_ld=1, pc_next=epc, flush=1, in_exc<=0, next state RET.
  - eret with in_exc=0 is ignored and falls through the priority chain.
REQ-023 RUN stall: pc_ld=0, flush=0, state unchanged.
REQ-024 RUN jump (wins over branch_taken): pc_ld=1, pc_next=jump_target, flush=0.
REQ-025 RUN branch_taken: pc_ld=1, pc_next=branch_target, flush=0.
REQ-026 RUN, nothing asserted:
  - pc_ld=1, pc_next=pc_cur+4, modulo 2^32.
  - 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-027 TRAP and RET:
  - One bubble cycle: pc_ld=0, fetch_valid=0, flush=0.
  - All inputs except reset are ignored; next state RUN.

Reset
REQ-028 While reset=1: pc_ld=1, pc_next=RESET_VECTOR, flush=1, fetch_valid=0, addr_err=0.
REQ-029 On a clock edge with reset=1: state<=BOOT, epc<=0, in_exc<=0, from any state including TRAP or RET.
REQ-030 Reset dominates exc_req, eret and stall in the same cycle.

Configuration
REQ-031 Macro PC_ALIGN_CHECK_EN defined:
  - In RUN, a selected jump, branch or eret target with bits[1:0]!=0 is replaced by exception behaviour (REQ-021).
  - addr_err=1 for that cycle.
REQ-032 Macro PC_ALIGN_CHECK_EN undefined:
  - Targets are used unchanged.
  - addr_err is tied to 0; the port remains present.

Structure
REQ-033 The shared package mips_pkg holds:
  - the pcseq_state_t state enum;
  - PC_INCR=4;
  - default RESET_VECTOR and EXC_VECTOR constants.
REQ-034 The priority target selection (REQ-020..026) is one combinational sub-module, pc_next_mux; the FSM and registers stay in pc_sequencer.

Verification
REQ-035 Reset release then idle, pc_cur follows pc_next:
  - BOOT loads 32'hBFC0_0000, then 32'hBFC0_0004, 32'hBFC0_0008.
  - fetch_valid=0 in BOOT, 1 after.
REQ-036 stall=1 for 3 cycles at pc_cur=32'h100: pc_ld=0 for 3 cycles; next load 32'h104.
REQ-037 jump=1 (target 32'h400) and branch_taken=1 (target 32'h200) in the same cycle: pc_next=32'h400, flush=0.
REQ-038 exc_req at pc_cur=32'h120 with stall=1:
  - pc_next=32'h8000_0180, epc=32'h120, in_exc=1, one TRAP bubble.
  - A later eret loads 32'h120, in_exc=0, one RET bubble.
REQ-039 Nested exc_req with in_exc=1 at pc_cur=32'h8000_0190: epc stays 32'h120; reset asserted in TRAP gives BOOT next cycle with epc=0.
REQ-040 With PC_ALIGN_CHECK_EN, jump to 32'h402:
  - addr_err=1, pc_next=32'h8000_0180.
  - Without the macro, pc_next=32'h402 and addr_err=0.
